// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl
// OV7670 capture front-end. The camera bus is oversampled in the i_clk domain.
// Byte pairs are assembled into RGB444 or RGB565 pixels. Kept pixels are
// streamed to the VGA path as 24-bit RGB with their post-decimation position.
// The same pixels are offered to the frame-buffer SRAM through a single-entry
// valid/ready holding register.
module cam_capture_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int ADDR_W    = 20,
  parameter int BASE_ADDR = 0,
  parameter int PIX_FMT   = 0,
  parameter int DECIM     = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cam_pclk,
  input  logic              i_cam_vsync,
  input  logic              i_cam_href,
  input  logic [7:0]        i_cam_data,
  output logic              o_wr_valid,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  input  logic              i_wr_ready,
  output logic              o_pix_valid,
  output logic [23:0]       o_rgb,
  output logic [9:0]        o_col,
  output logic [9:0]        o_row,
  output logic              o_frame_start,
  output logic              o_frame_done,
  input  logic              i_capture,
  input  logic              i_release,
  output logic              o_frozen,
  output logic              o_overflow,
  output logic              o_line_err
);

  localparam logic [2:0] S_WAIT_VS    = 3'd0;
  localparam logic [2:0] S_WAIT_FRAME = 3'd1;
  localparam logic [2:0] S_LINE       = 3'd2;
  localparam logic [2:0] S_BYTE0      = 3'd3;
  localparam logic [2:0] S_BYTE1      = 3'd4;
  localparam logic [2:0] S_FROZEN     = 3'd5;

  localparam int                LINE_W = H_ACTIVE / DECIM;
  localparam int                DSH    = (DECIM == 2) ? 1 : 0;
  localparam logic [11:0]       H_LIM  = 12'(H_ACTIVE);
  localparam logic [11:0]       V_LIM  = 12'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LINE_A = ADDR_W'(LINE_W);

  // SRAM word for a byte pair: RGB444 is left-aligned with a zero nibble.
  function automatic logic [15:0] pack_pix(input logic [7:0] b0, input logic [7:0] b1);
    if (PIX_FMT == 0) pack_pix = {b0[3:0], b1, 4'h0};
    else              pack_pix = {b0, b1};
  endfunction

  // Widen each channel to 8 bits by replicating its MSBs into the LSBs.
  function automatic logic [23:0] expand_pix(input logic [15:0] w);
    if (PIX_FMT == 0)
      expand_pix = {w[15:12], w[15:12], w[11:8], w[11:8], w[7:4], w[7:4]};
    else
      expand_pix = {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

  logic              pclk_p0, pclk_p1, pclk_p2;
  logic              vs_p0, vs_p1;
  logic              href_p0, href_p1;
  logic [7:0]        data_p0, data_p1;
  logic              byte_stb;
  logic [2:0]        state;
  logic [11:0]       raw_col, raw_row;
  logic [ADDR_W-1:0] row_base;
  logic [7:0]        byte0;
  logic              cap_pend;
  logic              col_ok, row_ok;
  logic [9:0]        kcol, krow;
  logic [15:0]       pix_word;

  // Control synchroniser flops; pclk keeps a third flop for edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pclk_p0 <= 1'b0;
      pclk_p1 <= 1'b0;
      pclk_p2 <= 1'b0;
      vs_p0   <= 1'b0;
      vs_p1   <= 1'b0;
      href_p0 <= 1'b0;
      href_p1 <= 1'b0;
    end else begin
      pclk_p0 <= i_cam_pclk;
      pclk_p1 <= pclk_p0;
      pclk_p2 <= pclk_p1;
      vs_p0   <= i_cam_vsync;
      vs_p1   <= vs_p0;
      href_p0 <= i_cam_href;
      href_p1 <= href_p0;
    end
  end

  // Data synchroniser and first-byte latch; these hold no control state.
  always_ff @(posedge i_clk) begin
    data_p0 <= i_cam_data;
    data_p1 <= data_p0;
    if (byte_stb && state == S_BYTE0) byte0 <= data_p1;
  end

  // ---- stage p1: synchronised bus, strobe and pixel classification ----
  assign byte_stb = pclk_p1 & ~pclk_p2;
  assign col_ok   = (raw_col < H_LIM) && ((DECIM == 1) || !raw_col[0]);
  assign row_ok   = (raw_row < V_LIM) && ((DECIM == 1) || !raw_row[0]);
  assign kcol     = 10'(raw_col >> DSH);
  assign krow     = 10'(raw_row >> DSH);
  assign pix_word = pack_pix(byte0, data_p1);
  assign o_frozen = (state == S_FROZEN);

  // Capture FSM, counters, write holding register and output pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_WAIT_VS;
      raw_col       <= '0;
      raw_row       <= '0;
      row_base      <= BASE_A;
      cap_pend      <= 1'b0;
      o_wr_valid    <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_pix_valid   <= 1'b0;
      o_rgb         <= '0;
      o_col         <= '0;
      o_row         <= '0;
      o_frame_start <= 1'b0;
      o_frame_done  <= 1'b0;
      o_overflow    <= 1'b0;
      o_line_err    <= 1'b0;
    end else begin
      o_pix_valid   <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_done  <= 1'b0;
      o_line_err    <= 1'b0;
      if (o_wr_valid && i_wr_ready) o_wr_valid <= 1'b0;
      // A release in S_FROZEN is handled below and overrides this latch.
      if (i_capture) cap_pend <= 1'b1;
      // ---- stage p2: registered outputs, one cycle after the strobe ----
      case (state)
        S_WAIT_VS: if (vs_p1) state <= S_WAIT_FRAME;
        S_WAIT_FRAME: begin
          if (!vs_p1) begin
            state         <= S_LINE;
            o_frame_start <= 1'b1;
            raw_row       <= '0;
            raw_col       <= '0;
            row_base      <= BASE_A;
            o_overflow    <= 1'b0;
          end
        end
        S_LINE, S_BYTE0, S_BYTE1: begin
          if (vs_p1) begin
            o_frame_done <= 1'b1;
            if (cap_pend) begin
              state      <= S_FROZEN;
              o_wr_valid <= 1'b0;
            end else begin
              state <= S_WAIT_FRAME;
            end
          end else if (state == S_LINE) begin
            // href is set up before the first pclk rise of a line, so the
            // level is enough to arm byte capture ahead of the first strobe.
            if (href_p1) state <= S_BYTE0;
          end else if (!href_p1) begin
            state   <= S_LINE;
            raw_col <= '0;
            raw_row <= (raw_row == 12'hFFF) ? raw_row : raw_row + 12'd1;
            // Advancing the row base per kept line realigns short lines.
            if (row_ok) begin
              row_base <= row_base + LINE_A;
              if (raw_col < H_LIM) o_line_err <= 1'b1;
            end
          end else if (byte_stb) begin
            if (state == S_BYTE0) begin
              state <= S_BYTE1;
            end else begin
              state   <= S_BYTE0;
              raw_col <= (raw_col == 12'hFFF) ? raw_col : raw_col + 12'd1;
              if (col_ok && row_ok) begin
                o_pix_valid <= 1'b1;
                o_rgb       <= expand_pix(pix_word);
                o_col       <= kcol;
                o_row       <= krow;
                if (o_wr_valid && !i_wr_ready) begin
                  o_overflow <= 1'b1;
                end else begin
                  o_wr_valid <= 1'b1;
                  o_wr_addr  <= row_base + ADDR_W'(kcol);
                  o_wr_data  <= pix_word;
                end
              end
            end
          end
        end
        S_FROZEN: begin
          if (i_release) begin
            cap_pend <= 1'b0;
            state    <= S_WAIT_VS;
          end
        end
        default: state <= S_WAIT_VS;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
`timescale 1ns/1ps
// tb_cam_capture_ctrl
// Two instances share one camera stream:
//   u_a : RGB565, no decimation, base 0
//   u_b : RGB444, 2x decimation, base 64
// Each frame's expected pixels, addresses and line errors come from the
// frame contents by plain arithmetic. Writes are scored by address order.
module tb_cam_capture_ctrl;
  localparam int H = 8;
  localparam int V = 4;
  localparam int BASE1 = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       pclk = 1'b0, vsync = 1'b0, href = 1'b0;
  logic [7:0] cdata = 8'h00;
  logic       capture = 1'b0, rel = 1'b0;
  logic       rdy [2];
  logic       wr_valid [2];
  logic [19:0] wr_addr [2];
  logic [15:0] wr_data [2];
  logic       pix_valid [2];
  logic [23:0] rgb [2];
  logic [9:0] col [2];
  logic [9:0] row [2];
  logic       fs [2], fd [2], frozen [2], ovf [2], lerr [2];

  cam_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(20), .BASE_ADDR(0),
                     .PIX_FMT(1), .DECIM(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_cam_pclk(pclk), .i_cam_vsync(vsync),
    .i_cam_href(href), .i_cam_data(cdata), .o_wr_valid(wr_valid[0]),
    .o_wr_addr(wr_addr[0]), .o_wr_data(wr_data[0]), .i_wr_ready(rdy[0]),
    .o_pix_valid(pix_valid[0]), .o_rgb(rgb[0]), .o_col(col[0]), .o_row(row[0]),
    .o_frame_start(fs[0]), .o_frame_done(fd[0]), .i_capture(capture),
    .i_release(rel), .o_frozen(frozen[0]), .o_overflow(ovf[0]), .o_line_err(lerr[0]));

  cam_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(20), .BASE_ADDR(BASE1),
                     .PIX_FMT(0), .DECIM(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_cam_pclk(pclk), .i_cam_vsync(vsync),
    .i_cam_href(href), .i_cam_data(cdata), .o_wr_valid(wr_valid[1]),
    .o_wr_addr(wr_addr[1]), .o_wr_data(wr_data[1]), .i_wr_ready(rdy[1]),
    .o_pix_valid(pix_valid[1]), .o_rgb(rgb[1]), .o_col(col[1]), .o_row(row[1]),
    .o_frame_start(fs[1]), .o_frame_done(fd[1]), .i_capture(capture),
    .i_release(rel), .o_frozen(frozen[1]), .o_overflow(ovf[1]), .o_line_err(lerr[1]));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int fmt_of(input int i);  return (i == 0) ? 1 : 0;     endfunction
  function automatic int dec_of(input int i);  return (i == 0) ? 1 : 2;     endfunction
  function automatic int base_of(input int i); return (i == 0) ? 0 : BASE1; endfunction

  // Channel expansion by arithmetic: x4 -> x*17, x5 -> x*8 + x/4, x6 -> x*4 + x/16.
  function automatic logic [23:0] m_rgb(input int fmt, input int b0, input int b1);
    int r, g, b, w;
    if (fmt == 0) begin
      r = (b0 % 16) * 17; g = (b1 / 16) * 17; b = (b1 % 16) * 17;
    end else begin
      w = b0 * 256 + b1;
      r = w / 2048; g = (w / 32) % 64; b = w % 32;
      r = r * 8 + r / 4; g = g * 4 + g / 16; b = b * 8 + b / 4;
    end
    return 24'(r * 65536 + g * 256 + b);
  endfunction

  function automatic logic [15:0] m_data(input int fmt, input int b0, input int b1);
    if (fmt == 0) return 16'((b0 % 16) * 4096 + b1 * 16);
    return 16'(b0 * 256 + b1);
  endfunction

  // Frame under test.
  logic [7:0] fb [0:5][0:23];
  int llen [0:5];
  int nrows;

  // Observations.
  logic [43:0] gp0[$], gp1[$];
  logic [35:0] gw0[$], gw1[$];
  int fs_n [2], fd_n [2], le_n [2];
  int rmode [2];
  int pix_idx;
  logic prev_pend [2];
  logic [35:0] prev_wr [2];

  // Monitor on the inactive edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst !== 1'b0) begin
        prev_pend[i] = 1'b0;
      end else begin
        if (prev_pend[i]) begin
          chk("wr_hold_valid", wr_valid[i], 1'b1);
          chk("wr_hold_addr_data", {wr_addr[i], wr_data[i]}, prev_wr[i]);
        end
        if (pix_valid[i] === 1'b1) begin
          if (i == 0) gp0.push_back({row[i], col[i], rgb[i]});
          else        gp1.push_back({row[i], col[i], rgb[i]});
        end
        if (wr_valid[i] === 1'b1 && rdy[i] === 1'b1) begin
          if (i == 0) gw0.push_back({wr_addr[i], wr_data[i]});
          else        gw1.push_back({wr_addr[i], wr_data[i]});
        end
        if (fs[i] === 1'b1)   fs_n[i]++;
        if (fd[i] === 1'b1)   fd_n[i]++;
        if (lerr[i] === 1'b1) le_n[i]++;
        prev_pend[i] = (wr_valid[i] === 1'b1) && (rdy[i] !== 1'b1);
        prev_wr[i]   = {wr_addr[i], wr_data[i]};
      end
    end
  end

  task automatic clear_obs();
    gp0.delete(); gp1.delete(); gw0.delete(); gw1.delete();
    for (int i = 0; i < 2; i++) begin fs_n[i] = 0; fd_n[i] = 0; le_n[i] = 0; end
  endtask

  task automatic set_rdy();
    for (int i = 0; i < 2; i++) begin
      case (rmode[i])
        1:       rdy[i] = ($urandom % 3) != 0;
        2:       rdy[i] = (pix_idx >= 3);
        default: rdy[i] = 1'b1;
      endcase
    end
  endtask

  // One camera byte: data/href change with pclk low, pclk high for 4 clocks.
  task automatic slot(input logic [7:0] d, input logic h);
    cdata = d; href = h; pclk = 1'b0;
    repeat (4) @(posedge clk);
    #1 pclk = 1'b1;
    repeat (4) @(posedge clk);
    #1 pclk = 1'b0;
  endtask

  task automatic do_reset_mid();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_wr_valid", wr_valid[i], 1'b0);
      chk("rst_wr_addr", wr_addr[i], 20'h0);
      chk("rst_pix_valid", pix_valid[i], 1'b0);
      chk("rst_rgb", rgb[i], 24'h0);
      chk("rst_overflow", ovf[i], 1'b0);
      chk("rst_frozen", frozen[i], 1'b0);
    end
    clear_obs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // kind: 0 nominal (fixed first pixels), 1 random with a long line, 2 short row 2, 3 random.
  task automatic fill_frame(input int kind);
    nrows = 5;
    for (int r = 0; r < 6; r++) begin
      llen[r] = H;
      for (int k = 0; k < 24; k++) fb[r][k] = 8'($urandom);
    end
    if (kind == 0) begin
      fb[0][0] = 8'h0A; fb[0][1] = 8'h5F; fb[0][2] = 8'hF8; fb[0][3] = 8'h1F;
    end
    if (kind == 1) llen[1] = 10;
    if (kind == 2) llen[2] = 5;
  endtask

  task automatic send_frame(input int cap_row, input int rst_row);
    clear_obs();
    pix_idx = 0;
    vsync = 1'b0;
    set_rdy();
    repeat (2) slot(8'h00, 1'b0);
    for (int r = 0; r < nrows; r++) begin
      if (r == cap_row) begin
        capture = 1'b1; rel = 1'b1;
        @(posedge clk); #1;
        capture = 1'b0; rel = 1'b0;
      end
      for (int c = 0; c < llen[r]; c++) begin
        set_rdy();
        slot(fb[r][2*c], 1'b1);
        if (r == rst_row && c == 3) do_reset_mid();
        set_rdy();
        slot(fb[r][2*c+1], 1'b1);
        pix_idx++;
      end
      set_rdy();
      repeat (3) slot(8'h00, 1'b0);
    end
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    repeat (3) slot(8'h00, 1'b0);
    vsync = 1'b1;
    repeat (4) slot(8'h00, 1'b0);
  endtask

  task automatic check_frame(input int i, input bit active);
    logic [43:0] gp[$], ep[$];
    logic [35:0] gw[$];
    int ea[$];
    logic [15:0] ed[$];
    int d, exp_le, j, n;
    bit found;
    if (i == 0) begin gp = gp0; gw = gw0; end else begin gp = gp1; gw = gw1; end
    d = dec_of(i);
    exp_le = 0;
    if (active) begin
      for (int r = 0; r < nrows; r++) begin
        if (r < V && r % d == 0) begin
          for (int c = 0; c < llen[r] && c < H; c++) begin
            if (c % d == 0) begin
              ep.push_back({10'(r / d), 10'(c / d),
                            m_rgb(fmt_of(i), int'(fb[r][2*c]), int'(fb[r][2*c+1]))});
              ea.push_back(base_of(i) + (r / d) * (H / d) + c / d);
              ed.push_back(m_data(fmt_of(i), int'(fb[r][2*c]), int'(fb[r][2*c+1])));
            end
          end
          if (llen[r] < H) exp_le++;
        end
      end
    end
    chk("pix_count", gp.size(), ep.size());
    n = (gp.size() < ep.size()) ? gp.size() : ep.size();
    for (int k = 0; k < n; k++) chk("pix_row_col_rgb", gp[k], ep[k]);
    j = 0;
    for (int k = 0; k < gw.size(); k++) begin
      found = 1'b0;
      while (j < ea.size() && !found) begin
        if (ea[j] == int'(gw[k][35:16])) found = 1'b1;
        else j++;
      end
      chk("wr_addr_in_order", found, 1'b1);
      if (found) begin
        chk("wr_data", gw[k][15:0], ed[j]);
        j++;
      end
    end
    if (rmode[i] == 0) chk("wr_count", gw.size(), ea.size());
    chk("overflow", ovf[i], gw.size() < ea.size());
    chk("frame_start_cnt", fs_n[i], active);
    chk("frame_done_cnt", fd_n[i], active);
    chk("line_err_cnt", le_n[i], exp_le);
  endtask

  initial begin
    rmode[0] = 0; rmode[1] = 0;
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    prev_pend[0] = 1'b0; prev_pend[1] = 1'b0;
    clear_obs();
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_wr_valid", wr_valid[i], 1'b0);
      chk("reset_pix_valid", pix_valid[i], 1'b0);
      chk("reset_frozen", frozen[i], 1'b0);
      chk("reset_overflow", ovf[i], 1'b0);
      chk("reset_frame_start", fs[i], 1'b0);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    vsync = 1'b1;
    repeat (4) slot(8'h00, 1'b0);

    // Nominal frame with fixed expansion vectors.
    fill_frame(0);
    send_frame(-1, -1);
    check_frame(0, 1'b1); check_frame(1, 1'b1);
    chk("rgb565_F81F", (gp0.size() > 1) ? gp0[1][23:0] : 24'hxxxxxx, 24'hFF00FF);
    chk("rgb444_0A5F", (gp1.size() > 0) ? gp1[0][23:0] : 24'hxxxxxx, 24'hAA55FF);
    chk("wr444_0A5F", (gw1.size() > 0) ? gw1[0][15:0] : 16'hxxxx, 16'hA5F0);
    chk("decim_base_addr", (gw1.size() > 0) ? gw1[0][35:16] : 20'hxxxxx, 20'(BASE1));
    chk("decim_col3", (gp1.size() > 3) ? gp1[3][33:24] : 10'hxxx, 10'd3);
    chk("decim_wr_count", gw1.size(), 8);

    // Random data, random ready, over-long row 1.
    rmode[0] = 1; rmode[1] = 1;
    fill_frame(1);
    send_frame(-1, -1);
    check_frame(0, 1'b1); check_frame(1, 1'b1);

    // Back-pressure on u_a: ready low for the first three pixels.
    rmode[0] = 2; rmode[1] = 0;
    fill_frame(3);
    send_frame(-1, -1);
    check_frame(0, 1'b1); check_frame(1, 1'b1);
    chk("bp_first_addr", (gw0.size() > 0) ? gw0[0][35:16] : 20'hxxxxx, 20'd0);
    chk("bp_first_data", (gw0.size() > 0) ? gw0[0][15:0] : 16'hxxxx, {fb[0][0], fb[0][1]});
    chk("bp_next_addr", (gw0.size() > 1) ? gw0[1][35:16] : 20'hxxxxx, 20'd3);
    chk("bp_overflow", ovf[0], 1'b1);

    // Short row 2.
    rmode[0] = 0;
    fill_frame(2);
    send_frame(-1, -1);
    check_frame(0, 1'b1); check_frame(1, 1'b1);
    chk("short_row3_addr", (gw0.size() > 21) ? gw0[21][35:16] : 20'hxxxxx, 20'd24);

    // Capture (with a simultaneous release while not frozen) mid-frame.
    fill_frame(3);
    send_frame(1, -1);
    check_frame(0, 1'b1); check_frame(1, 1'b1);
    chk("frozen_after_frame_a", frozen[0], 1'b1);
    chk("frozen_after_frame_b", frozen[1], 1'b1);
    for (int f = 0; f < 2; f++) begin
      fill_frame(3);
      send_frame(-1, -1);
      check_frame(0, 1'b0); check_frame(1, 1'b0);
      chk("still_frozen", frozen[0], 1'b1);
    end

    // Release together with capture while frozen: release wins.
    capture = 1'b1; rel = 1'b1;
    @(posedge clk); #1;
    capture = 1'b0; rel = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("released_a", frozen[0], 1'b0);
    chk("released_b", frozen[1], 1'b0);
    fill_frame(3);
    send_frame(-1, -1);
    check_frame(0, 1'b1); check_frame(1, 1'b1);
    chk("resume_first_addr", (gw0.size() > 0) ? gw0[0][35:16] : 20'hxxxxx, 20'd0);
    chk("no_refreeze", frozen[0], 1'b0);

    // Reset in the middle of row 1: nothing more until the next frame.
    fill_frame(3);
    send_frame(-1, 1);
    chk("post_rst_pix_a", gp0.size(), 0);
    chk("post_rst_wr_b", gw1.size(), 0);
    chk("post_rst_done", fd_n[0], 0);
    rmode[0] = 1; rmode[1] = 1;
    fill_frame(1);
    send_frame(-1, -1);
    check_frame(0, 1'b1); check_frame(1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
